// File: rtl/ksa16_sub_pipe_pkg.sv
// Shared constants and payload types for the 16-bit Kogge-Stone subtractor pipeline.
package ksa16_sub_pipe_pkg;

   localparam int unsigned KSA_W       = 16;
   localparam int unsigned KSA_LVLS    = 4;
   localparam int unsigned KSA_S1_LVLS = 2;
   localparam int unsigned KSA_SPAN1   = 1;
   localparam int unsigned KSA_SPAN2   = 2;
   localparam int unsigned KSA_SPAN4   = 4;
   localparam int unsigned KSA_SPAN8   = 8;

   // Stage-1 payload: half sum, partial prefix G/P, operand sign bits.
   typedef struct packed {
      logic [KSA_W-1:0] hs;
      logic [KSA_W-1:0] g;
      logic [KSA_W-1:0] p;
      logic             a_msb;
      logic             b_msb;
   } s1_t;

   typedef struct packed {
      logic [KSA_W-1:0] diff;
      logic             borrow;
      logic             ovf;
   } res_t;

   function automatic int unsigned ksa_span(int unsigned lvl);
      case (lvl)
         0:       return KSA_SPAN1;
         1:       return KSA_SPAN2;
         2:       return KSA_SPAN4;
         default: return KSA_SPAN8;
      endcase
   endfunction

endpackage

// File: rtl/ksa16_sub_pipe_if.sv
// Operand/result handshake bundle for ksa16_sub_pipe.
interface ksa16_sub_pipe_if;
   import ksa16_sub_pipe_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [KSA_W-1:0] a;
   logic [KSA_W-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [KSA_W-1:0] diff;
   logic             borrow;
   logic             ovf;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow, ovf
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow, ovf
   );

endinterface

// File: rtl/ksa_prefix_cell.sv
// Kogge-Stone black cell; used as a gray cell by ignoring p.
module ksa_prefix_cell (
   input  logic gh,
   input  logic ph,
   input  logic gl,
   input  logic pl,
   output logic g,
   output logic p
);

   assign g = gh | (ph & gl);
   assign p = ph & pl;

endmodule

// File: rtl/ksa16_sub_pipe.sv
// Two-stage pipelined a - b using a Kogge-Stone prefix network (span 1/2 in stage 1, span 4/8 in stage 2).
module ksa16_sub_pipe
   import ksa16_sub_pipe_pkg::*;
(
`ifdef USE_POWER_PINS
   inout wire              vdd,
   inout wire              vss,
`endif
   input  logic            wb_clk_i,
   input  logic            wb_rst_n,
   ksa16_sub_pipe_if.slave bus
);

   logic             s1_valid;
   logic             s2_valid;
   logic             s1_adv;
   logic             s2_adv;
   s1_t              s1_d;
   s1_t              s1_q;
   res_t             res_d;
   res_t             res_q;
   logic [KSA_W-1:0] hs;
   logic [KSA_W-1:0] g0;
   logic [KSA_W-1:0] c;
   logic             p_unused;

   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv;

   // a + ~b + 1: the carry-in is folded into bit 0 as g0 | p0.
   assign hs = bus.a ^ ~bus.b;
   assign g0 = (bus.a & ~bus.b) | KSA_W'(hs[0]);

   for (genvar k = 0; k < KSA_LVLS; k++) begin : g_lvl
      logic [KSA_W-1:0] gi;
      logic [KSA_W-1:0] pi;
      logic [KSA_W-1:0] go;
      logic [KSA_W-1:0] po;

      if (k == 0) begin : g_in
         assign gi = g0;
         assign pi = hs;
      end else if (k == KSA_S1_LVLS) begin : g_reg
         assign gi = s1_q.g;
         assign pi = s1_q.p;
      end else begin : g_prev
         assign gi = g_lvl[k-1].go;
         assign pi = g_lvl[k-1].po;
      end

      for (genvar i = 0; i < KSA_W; i++) begin : g_bit
         if (i >= int'(ksa_span(k))) begin : g_cell
            ksa_prefix_cell u_cell (
               .gh (gi[i]),
               .ph (pi[i]),
               .gl (gi[i - int'(ksa_span(k))]),
               .pl (pi[i - int'(ksa_span(k))]),
               .g  (go[i]),
               .p  (po[i])
            );
         end else begin : g_pass
            assign go[i] = gi[i];
            assign po[i] = pi[i];
         end
      end
   end

   // Final-level group propagate has no consumer.
   assign p_unused = ^g_lvl[KSA_LVLS-1].po;

   always_comb begin
      s1_d       = '0;
      s1_d.hs    = hs;
      s1_d.g     = g_lvl[KSA_S1_LVLS-1].go;
      s1_d.p     = g_lvl[KSA_S1_LVLS-1].po;
      s1_d.a_msb = bus.a[KSA_W-1];
      s1_d.b_msb = bus.b[KSA_W-1];
   end

   assign c = g_lvl[KSA_LVLS-1].go;

   always_comb begin
      res_d        = '0;
      res_d.diff   = s1_q.hs ^ {c[KSA_W-2:0], 1'b1};
      res_d.borrow = ~c[KSA_W-1];
      res_d.ovf    = (s1_q.a_msb != s1_q.b_msb) && (res_d.diff[KSA_W-1] != s1_q.a_msb);
   end

   // Each stage loads only when it can advance; otherwise it holds.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_q     <= '0;
         res_q    <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= bus.in_valid;
            s1_q     <= s1_d;
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            res_q    <= res_d;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.diff      = res_q.diff;
   assign bus.borrow    = res_q.borrow;
   assign bus.ovf       = res_q.ovf;

endmodule

// File: tb/tb_ksa16_sub_pipe.sv
// Scoreboard bench for ksa16_sub_pipe: directed corner cases, backpressure, reset, random traffic.
module tb_ksa16_sub_pipe;
   import ksa16_sub_pipe_pkg::*;

   typedef struct {
      logic [15:0] diff;
      logic        borrow;
      logic        ovf;
      int          acc;
   } exp_t;

   logic wb_clk_i;
   logic wb_rst_n;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_push = 0;
   logic exp_ov;
   exp_t q[$];

   ksa16_sub_pipe_if bus();

   ksa16_sub_pipe dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_n (wb_rst_n),
      .bus      (bus)
   );

   initial begin
      wb_clk_i = 1'b0;
      forever #5 wb_clk_i = ~wb_clk_i;
   end

   always @(posedge wb_clk_i) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: plain 17-bit unsigned and 32-bit signed arithmetic.
   function automatic exp_t model(input logic [15:0] va, input logic [15:0] vb, input int acc);
      logic [16:0] w;
      int          sd;
      exp_t        e;
      w = {1'b0, va} - {1'b0, vb};
      sd = int'($signed(va)) - int'($signed(vb));
      e.diff   = w[15:0];
      e.borrow = w[16];
      e.ovf    = (sd > 32767) || (sd < -32768);
      e.acc    = acc;
      return e;
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'h0001;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         4:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Input side: every accepted pair pushes its expected result.
   always @(negedge wb_clk_i) begin
      #1;
      if (wb_rst_n && bus.in_valid && bus.in_ready) begin
         q.push_back(model(bus.a, bus.b, cyc + 1));
         n_push++;
      end
   end

   // Output side: occupancy-based ready/valid expectations and in-order result check.
   always @(negedge wb_clk_i) begin
      if (wb_rst_n) begin
         exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 1);
         chk("in_ready", 32'(bus.in_ready), 32'(!((q.size() >= 2) && !bus.out_ready)));
         chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
         if (bus.out_valid && q.size() > 0) begin
            chk("diff", 32'(bus.diff), 32'(q[0].diff));
            chk("borrow", 32'(bus.borrow), 32'(q[0].borrow));
            chk("ovf", 32'(bus.ovf), 32'(q[0].ovf));
            if (bus.out_ready) void'(q.pop_front());
         end
      end
   end

   task automatic dir(input logic [15:0] va, input logic [15:0] vb,
                      input logic [15:0] ed, input logic eb, input logic eo);
      @(posedge wb_clk_i); #1;
      bus.in_valid  = 1'b1;
      bus.a         = va;
      bus.b         = vb;
      bus.out_ready = 1'b1;
      @(posedge wb_clk_i); #1;
      bus.in_valid = 1'b0;
      @(negedge wb_clk_i);
      chk("dir_lat1_valid", 32'(bus.out_valid), 32'(0));
      @(negedge wb_clk_i);
      chk("dir_lat2_valid", 32'(bus.out_valid), 32'(1));
      chk("dir_diff", 32'(bus.diff), 32'(ed));
      chk("dir_borrow", 32'(bus.borrow), 32'(eb));
      chk("dir_ovf", 32'(bus.ovf), 32'(eo));
   endtask

   task automatic drain();
      @(posedge wb_clk_i); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         @(negedge wb_clk_i); #2;
      end
      chk("drain_empty", 32'(q.size()), 32'(0));
   endtask

   initial begin
      int target;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      wb_rst_n      = 1'b1;
      #1 wb_rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
      chk("rst_diff", 32'(bus.diff), 32'(0));
      chk("rst_borrow", 32'(bus.borrow), 32'(0));
      chk("rst_ovf", 32'(bus.ovf), 32'(0));
      repeat (3) @(posedge wb_clk_i);
      #1 wb_rst_n = 1'b1;

      dir(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
      dir(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
      dir(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
      dir(16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);
      dir(16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0);

      // Backpressure: three back-to-back pairs, consumer stalled for four cycles.
      @(posedge wb_clk_i); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.a = 16'h0005; bus.b = 16'h0001;
      @(negedge wb_clk_i);
      chk("bp_ready_1", 32'(bus.in_ready), 32'(1));
      @(posedge wb_clk_i); #1;
      bus.a = 16'h0010; bus.b = 16'h0003;
      @(negedge wb_clk_i);
      chk("bp_ready_2", 32'(bus.in_ready), 32'(1));
      @(posedge wb_clk_i); #1;
      bus.a = 16'h0100; bus.b = 16'h0100;
      @(negedge wb_clk_i);
      chk("bp_ready_low", 32'(bus.in_ready), 32'(0));
      chk("bp_stall_diff_a", 32'(bus.diff), 32'(16'h0004));
      @(posedge wb_clk_i); #1;
      @(negedge wb_clk_i);
      chk("bp_ready_low2", 32'(bus.in_ready), 32'(0));
      chk("bp_stall_valid", 32'(bus.out_valid), 32'(1));
      chk("bp_stall_diff_b", 32'(bus.diff), 32'(16'h0004));
      @(posedge wb_clk_i); #1;
      bus.out_ready = 1'b1;
      @(negedge wb_clk_i);
      chk("bp_ready_back", 32'(bus.in_ready), 32'(1));
      drain();

      // Reset with two results in flight.
      @(posedge wb_clk_i); #1;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      bus.a = 16'h4444; bus.b = 16'h1111;
      @(posedge wb_clk_i); #1;
      bus.a = 16'h0002; bus.b = 16'h0009;
      @(posedge wb_clk_i); #1;
      bus.in_valid = 1'b0;
      chk("pre_rst_valid", 32'(bus.out_valid), 32'(1));
      #1 wb_rst_n = 1'b0;
      #1;
      q.delete();
      chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
      chk("mid_rst_ready", 32'(bus.in_ready), 32'(1));
      chk("mid_rst_diff", 32'(bus.diff), 32'(0));
      repeat (2) @(posedge wb_clk_i);
      #1 wb_rst_n = 1'b1;
      repeat (6) @(negedge wb_clk_i);
      dir(16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);

      // Random traffic with periodic full-rate bursts.
      target = n_push + 10000;
      for (int c = 0; c < 60000 && n_push < target; c++) begin
         @(posedge wb_clk_i); #1;
         bus.in_valid  = ((c % 1000) < 100) || ($urandom_range(0, 3) != 0);
         bus.out_ready = ((c % 1000) < 100) || ($urandom_range(0, 3) != 0);
         bus.a = pick();
         bus.b = pick();
      end
      chk("rand_accepted", 32'(n_push >= target), 32'(1));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ksa16_sub_pipe.md
KSA16_SUB_PIPE -- requirements
Module: ksa16_sub_pipe

Interface
REQ-001 Parameters: none; the operand width is fixed at 16 and comes from the shared package.
REQ-002 wb_clk_i  input  1  single clock; all flops are rising-edge.
REQ-003 wb_rst_n  input  1  asynchronous, active-low reset.
REQ-004 vdd, vss  inout  1  power pins, present only under USE_POWER_PINS.
REQ-005 in_valid  input  1  operand pair on a/b is valid.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 a  input  16  minuend, unsigned or two's complement.
REQ-008 b  input  16  subtrahend.
REQ-009 out_valid  output  1  result fields are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 diff  output  16  result a - b mod 2^16.
REQ-012 borrow  output  1  set when a < b, unsigned.
REQ-013 ovf  output  1  signed overflow of a - b.

Function
REQ-014 The block SHALL compute a + ~b + 1 with a 16-bit Kogge-Stone parallel-prefix carry network.
- The carry-in of 1 is folded in as g0' = g0 | p0.
- No ripple chain is used.
REQ-015 Stage 1 SHALL register half-sum p = a ^ ~b and the prefix group generate/propagate after the span-1 and span-2 levels.
REQ-016 Stage 2 SHALL compute:
- the span-4 and span-8 levels;
- diff = p ^ {c[14:0], 1'b1};
- borrow = ~c[15];
- ovf = (a[15] != b[15]) && (diff[15] != a[15]). a[15] and b[15] are carried through stage 1.
Stage 2 registers these outputs.
REQ-017 Latency SHALL be exactly 2 cycles from an in_valid && in_ready handshake to out_valid, when out_ready is held high.
REQ-018 Throughput SHALL be one result per cycle with no bubbles while out_ready is high.
REQ-019 Each stage SHALL hold a valid bit; s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
REQ-020 A stage register SHALL load only when its advance term is true.
- A stage whose advance term is false holds its data and valid bit unchanged.
- Stage 1's valid loads in_valid.
- Stage 2's valid loads s1_valid.
REQ-021 While out_valid is high and out_ready is low, diff, borrow and ovf SHALL remain stable.
REQ-022 At most 2 transactions SHALL be in flight.
- in_ready is low only when both stages are valid and out_ready is low.
REQ-023 Results SHALL emerge in acceptance order; no transaction is dropped or duplicated.
REQ-024 in_valid low SHALL insert a bubble that propagates as out_valid low 2 cycles later.
REQ-025 in_ready SHALL depend combinationally only on the valid bits and out_ready, never on in_valid.
REQ-026 Wrap-around is defined: 0x0000 - 0x0001 = 0xFFFF with borrow = 1.

Reset
REQ-027 Asserting wb_rst_n low SHALL immediately clear both stage valid bits, regardless of the clock.
REQ-028 During reset, out_valid, diff, borrow and ovf SHALL be 0 and in_ready SHALL be 1.
REQ-029 Transactions in flight at reset SHALL be discarded.
- After deassertion, the first accepted pair yields the first result.
REQ-030 Reset deassertion SHALL be synchronized externally; the block adds no reset synchronizer.

Structure
REQ-031 The shared package SHALL hold:
- KSA_W = 16;
- the prefix level count, 4;
- the span constants 1, 2, 4, 8.
REQ-032 One sub-module, ksa_prefix_cell, SHALL implement the black cell: G = Gh | (Ph & Gl), P = Ph & Pl.
- A gray cell is the same module with P unused.
REQ-033 The prefix levels SHALL be generate loops over ksa_prefix_cell; there is no behavioural "-" operator on the datapath.

Verification
REQ-034 a=0x0000, b=0x0001, out_ready=1 -> 2 cycles later diff=0xFFFF, borrow=1, ovf=0.
REQ-035 a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1; a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1.
REQ-036 a=b=0x1234 -> diff=0x0000, borrow=0, ovf=0; a=0xFFFF, b=0x0000 -> diff=0xFFFF, borrow=0.
REQ-037 Backpressure case:
- Stimulus: feed 0x0005-0x0001, 0x0010-0x0003, 0x0100-0x0100 back-to-back with out_ready=0 for 4 cycles.
- Response: in_ready falls after 2 accepts.
- Response: after out_ready rises, outputs are 0x0004, 0x000D, 0x0000 in order, stable while stalled.
REQ-038 Reset mid-operation: pulse wb_rst_n low with 2 results in flight -> out_valid=0 at once; no stale result after release.
REQ-039 Random 10000 pairs with random in_valid/out_ready -> every result matches the reference model {borrow, diff} = {1'b0, a} - {1'b0, b}, and ovf matches.
- Full throughput is observed whenever in_valid = out_ready = 1.
